// File: rtl/data_mem_responder_pkg.sv
// Shared core-wide constants and responder FSM encodings.
// Imported by the responder top and its memory bank.
package data_mem_responder_pkg;

    localparam int DEF_N_CORES        = 4;
    localparam int DEF_MEM_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH     = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_STALL  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_ACCESS = ST_ACCESS,
        S_STALL  = ST_STALL,
        S_DONE   = ST_DONE
    } state_t;

endpackage

// File: rtl/data_mem_responder_mem_bank.sv
// Single-port data memory bank: synchronous write, combinational read.
// Contents are deliberately not reset.
module mem_bank
    import data_mem_responder_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [MEM_ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the SM core memory handshake: snapshots a request and
// serializes enabled lanes onto one bank, then pulses MReady once.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int N_CORES        = DEF_N_CORES,
    parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int WAIT_CYCLES    = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 MRead,
    input  logic                                 MWrite,
    output logic                                 MReady,
    input  logic [N_CORES-1:0]                   en_mask,
    input  logic [N_CORES*MEM_ADDR_WIDTH-1:0]    addr_array,
    input  logic [N_CORES*DATA_WIDTH-1:0]        wdata_array,
    output logic [N_CORES*DATA_WIDTH-1:0]        rdata_array,
    output logic                                 busy
);

    localparam int LW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    state_t                                     state, state_n;
    logic [LW-1:0]                              lane, lane_n;
    logic [3:0]                                 stall_cnt, stall_n;
    logic                                       op_wr;
    logic [N_CORES-1:0]                         mask_q;
    logic [N_CORES-1:0][MEM_ADDR_WIDTH-1:0]     addr_q;
    logic [N_CORES-1:0][DATA_WIDTH-1:0]         wdata_q;
    logic [N_CORES-1:0][DATA_WIDTH-1:0]         rdata_q;
    logic                                       accept, bank_we, rd_ld, lane_on, last_lane;
    logic [DATA_WIDTH-1:0]                      bank_rdata;

    assign lane_on   = mask_q[lane];
    assign last_lane = (lane == LW'(N_CORES - 1));

    always_comb begin
        state_n = state;
        lane_n  = lane;
        stall_n = stall_cnt;
        accept  = 1'b0;
        bank_we = 1'b0;
        rd_ld   = 1'b0;
        case (state)
            S_IDLE: begin
                if (MRead || MWrite) begin
                    accept  = 1'b1;
                    lane_n  = '0;
                    state_n = S_ACCESS;
                end
            end
            S_ACCESS: begin
                bank_we = lane_on && op_wr;
                rd_ld   = lane_on && !op_wr;
                stall_n = '0;
                if (lane_on && WAIT_CYCLES > 0) state_n = S_STALL;
                else if (last_lane)             state_n = S_DONE;
                else                            lane_n  = lane + 1'b1;
            end
            S_STALL: begin
                if (stall_cnt == 4'(WAIT_CYCLES - 1)) begin
                    if (last_lane) begin
                        state_n = S_DONE;
                    end else begin
                        lane_n  = lane + 1'b1;
                        state_n = S_ACCESS;
                    end
                end else begin
                    stall_n = stall_cnt + 4'd1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            lane      <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_n;
            lane      <= lane_n;
            stall_cnt <= stall_n;
        end
    end

    // Request snapshot; write wins when both levels are high.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_wr   <= 1'b0;
            mask_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            op_wr   <= MWrite;
            mask_q  <= en_mask;
            addr_q  <= addr_array;
            wdata_q <= wdata_array;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)      rdata_q       <= '0;
        else if (rd_ld) rdata_q[lane] <= bank_rdata;
    end

    // Gate the write with reset so an aborted lane never lands in the bank.
    mem_bank #(
        .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we && !reset),
        .addr  (addr_q[lane]),
        .wdata (wdata_q[lane]),
        .rdata (bank_rdata)
    );

    assign rdata_array = rdata_q;
    assign MReady      = (state == S_DONE);
    assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of request vectors on a
// zero-wait instance plus hand sequences for reset abort, re-accept and stalls.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              rd0, wr0, rdy0, busy0, rd1, wr1, rdy1, busy1;
    logic [3:0]        mask0, mask1;
    logic [3:0][7:0]   addr0, addr1;
    logic [3:0][15:0]  wdata0, wdata1, rdata0, rdata1;

    data_mem_responder #(.N_CORES(4), .MEM_ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .MRead(rd0), .MWrite(wr0), .MReady(rdy0),
        .en_mask(mask0), .addr_array(addr0), .wdata_array(wdata0),
        .rdata_array(rdata0), .busy(busy0));

    data_mem_responder #(.N_CORES(4), .MEM_ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_CYCLES(2)) dut1 (
        .clk(clk), .reset(reset), .MRead(rd1), .MWrite(wr1), .MReady(rdy1),
        .en_mask(mask1), .addr_array(addr1), .wdata_array(wdata1),
        .rdata_array(rdata1), .busy(busy1));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit which, input logic rd, input logic wr, input logic [3:0] m,
                         input logic [3:0][7:0] a, input logic [3:0][15:0] d);
        if (!which) begin rd0 = rd; wr0 = wr; mask0 = m; addr0 = a; wdata0 = d; end
        else        begin rd1 = rd; wr1 = wr; mask1 = m; addr1 = a; wdata1 = d; end
    endtask

    // Issue one request, scramble inputs after acceptance, return cycles to MReady.
    task automatic run_req(input bit which, input logic wr, input logic [3:0] m,
                           input logic [3:0][7:0] a, input logic [3:0][15:0] d,
                           output int lat);
        @(negedge clk);
        drive(which, !wr, wr, m, a, d);
        @(posedge clk);
        #1 drive(which, !wr, wr, ~m, ~a, ~d);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if ((which ? rdy1 : rdy0) === 1'b1) begin lat = k; break; end
        end
        drive(which, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("pulse_width", {62'd0, (which ? rdy1 : rdy0), (which ? busy1 : busy0)}, 64'd0);
    endtask

    typedef struct {
        logic             wr;
        logic [3:0]       mask;
        logic [3:0][7:0]  a;
        logic [3:0][15:0] d;
        int               lat;
        logic [3:0][15:0] exp;
    } vec_t;

    vec_t v [8];
    int   lat;

    initial begin
        v[0] = '{1'b1, 4'hF, {8'd4, 8'd3, 8'd2, 8'd1}, {16'h44, 16'h33, 16'h22, 16'h11}, 5, 64'd0};
        v[1] = '{1'b0, 4'hF, {8'd4, 8'd3, 8'd2, 8'd1}, 64'd0, 5, {16'h44, 16'h33, 16'h22, 16'h11}};
        v[2] = '{1'b1, 4'hF, {8'd13, 8'd12, 8'd11, 8'd10}, {16'h400, 16'h300, 16'h200, 16'h100}, 5,
                 {16'h44, 16'h33, 16'h22, 16'h11}};
        v[3] = '{1'b0, 4'b0101, {8'd13, 8'd12, 8'd11, 8'd10}, 64'd0, 5, {16'h44, 16'h300, 16'h22, 16'h100}};
        v[4] = '{1'b1, 4'hF, {8'd7, 8'd7, 8'd7, 8'd7}, {16'hD, 16'hC, 16'hB, 16'hA}, 5,
                 {16'h44, 16'h300, 16'h22, 16'h100}};
        v[5] = '{1'b0, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd7}, 64'd0, 5, {16'h44, 16'h300, 16'h22, 16'hD}};
        v[6] = '{1'b0, 4'b0000, {8'd7, 8'd7, 8'd7, 8'd7}, 64'd0, 5, {16'h44, 16'h300, 16'h22, 16'hD}};
        v[7] = '{1'b0, 4'b1000, {8'd1, 8'd0, 8'd0, 8'd0}, 64'd0, 5, {16'h11, 16'h300, 16'h22, 16'hD}};

        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_ready_busy", {62'd0, rdy0, busy0}, 64'd0);
        chk("reset_rdata", rdata0, 64'd0);

        foreach (v[i]) begin
            run_req(1'b0, v[i].wr, v[i].mask, v[i].a, v[i].d, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(v[i].lat));
            chk($sformatf("vec%0d_rdata", i), rdata0, v[i].exp);
        end

        // Reset during lane 2 of a write: lanes 0,1 land, 2,3 keep old data.
        run_req(1'b0, 1'b1, 4'hF, {8'd33, 8'd32, 8'd31, 8'd30},
                {16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA}, lat);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 4'hF, {8'd33, 8'd32, 8'd31, 8'd30}, {16'h4, 16'h3, 16'h2, 16'h1});
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (rdy0 === 1'b1) lat++;
        end
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (rdy0 === 1'b1) lat++;
            @(negedge clk);
        end
        chk("abort_no_ready", 64'(lat), 64'd0);
        chk("abort_idle_rdata", {rdata0[3:1], 14'd0, rdy0, busy0}, 64'd0);
        run_req(1'b0, 1'b0, 4'hF, {8'd33, 8'd32, 8'd31, 8'd30}, '0, lat);
        chk("abort_readback", rdata0, {16'hAAAA, 16'hAAAA, 16'h2, 16'h1});

        // Request held past MReady is accepted again from the IDLE cycle.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 4'hF, {8'd4, 8'd3, 8'd2, 8'd1}, '0);
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rdy0 === 1'b1) begin lat = k; break; end
        end
        chk("hold_first_latency", 64'(lat), 64'd5);
        @(negedge clk);
        chk("hold_idle_cycle", {62'd0, rdy0, busy0}, 64'd0);
        @(negedge clk);
        chk("hold_reaccept_busy", {63'd0, busy0}, 64'd1);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rdy0 === 1'b1) begin lat = k; break; end
        end
        chk("hold_second_latency", 64'(lat), 64'd4);

        // Two wait cycles per enabled lane, two lanes enabled.
        run_req(1'b1, 1'b1, 4'b0011, {8'd23, 8'd22, 8'd21, 8'd20}, {16'h4, 16'h3, 16'h2, 16'h1}, lat);
        chk("wait_write_latency", 64'(lat), 64'd9);
        run_req(1'b1, 1'b0, 4'b0011, {8'd23, 8'd22, 8'd21, 8'd20}, '0, lat);
        chk("wait_read_latency", 64'(lat), 64'd9);
        chk("wait_read_rdata", rdata1, {16'h0, 16'h0, 16'h2, 16'h1});
        run_req(1'b1, 1'b0, 4'b0000, '0, '0, lat);
        chk("wait_masked_latency", 64'(lat), 64'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
